// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: default sizes and the decoded command type.
// No logic here; imported by the stack RTL and its bench.
// Backpressure: not applicable.
package stack_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  localparam int CNT_W     = $clog2(DEF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    PUSH,
    POP,
    REPL
  } stack_cmd_e;
endpackage

// File: rtl/stack_unit_if.sv
// Command/data bundle between the stack-machine controller and the operand stack.
// Latency: wires only. Backpressure: none; commands are accepted every cycle.
// Error flags exist only when STACK_ERR_EN is defined.
interface stack_unit_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic             tos;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
`ifdef STACK_ERR_EN
  logic             overflow;
  logic             underflow;
`endif

  modport master (
    output push, pop, tos, din,
    input  dout, count, empty, full
`ifdef STACK_ERR_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  push, pop, tos, din,
    output dout, count, empty, full
`ifdef STACK_ERR_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/stack_ram.sv
// Body storage under the top register: DEPTH-1 words, one synchronous write, async read.
// Latency: write visible the cycle after the edge; read is combinational.
// Backpressure: none.
module stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);
  logic [WIDTH-1:0] mem [0:DEPTH-2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // The read address wraps past the array when fewer than two elements are stored;
  // the value is unused then, so return zero instead of indexing out of range.
  assign rd_dat = (int'(rd_addr) < DEPTH - 1) ? mem[rd_addr] : '0;
endmodule

// File: rtl/stack_unit.sv
// Operand stack with the top element in a register for zero-latency reads; STACK_ERR_EN adds sticky overflow/underflow.
// Latency: one cycle from command edge to dout/count/empty/full.
// Backpressure: none; illegal push/pop are dropped (and flagged when enabled).
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  stack_unit_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] top_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_m1;
  logic [CW-1:0]    cnt_m2;
  logic             is_empty;
  logic             is_full;
  logic             ram_we;
  logic [WIDTH-1:0] rd_dat;
  stack_cmd_e       cmd;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CW'(DEPTH));
  assign cnt_m1   = cnt_q - CW'(1);
  assign cnt_m2   = cnt_q - CW'(2);

  // Replace wins over push; push/pop together on an empty stack falls through to push.
  always_comb begin
    cmd = IDLE;
    if (bus.push && bus.pop && !is_empty) begin
      cmd = REPL;
    end else if (bus.push && !is_full) begin
      cmd = PUSH;
    end else if (bus.pop && !bus.push && !is_empty) begin
      cmd = POP;
    end
  end

  // The old top spills into the body only when there was something on top.
  assign ram_we = (cmd == PUSH) && !is_empty;

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (AW'(cnt_m1)),
    .wr_dat  (top_q),
    .rd_addr (AW'(cnt_m2)),
    .rd_dat  (rd_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      case (cmd)
        PUSH: begin
          top_q <= bus.din;
          cnt_q <= cnt_q + CW'(1);
        end
        POP: begin
          top_q <= (cnt_q == CW'(1)) ? '0 : rd_dat;
          cnt_q <= cnt_m1;
        end
        REPL: begin
          top_q <= bus.din;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.dout  = top_q;
  assign bus.count = cnt_q;
  assign bus.empty = is_empty;
  assign bus.full  = is_full;

`ifdef STACK_ERR_EN
  logic ovf_q;
  logic unf_q;
  logic ovf_set;
  logic unf_set;

  assign ovf_set = bus.push && !bus.pop && is_full;
  assign unf_set = is_empty && !bus.push && (bus.pop || bus.tos);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif
endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware operand stack that answers the push/pop/top-of-stack commands the stack-machine controller issues. It sits inside the datapath between the stack-source mux (`din`) and the ALU/B-register inputs (`dout`). The top element is held in a dedicated register, so the top is readable with zero latency. Capacity is bounded and checked. Misuse (push when full, pop when empty) is rejected and reported.

## Interface
Parameters:
- `WIDTH`, default 8: data word width in bits; matches the 8-bit instruction/data path.
- `DEPTH`, default 16: maximum number of stored elements, counting the top register. Must be a power of 2 and ≥ 2.

Ports:
- `clk`, in, 1: single clock; every register updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `push`, in, 1: push `din` this cycle.
- `pop`, in, 1: pop the top element this cycle.
- `tos`, in, 1: top-of-stack read strobe; used only for underflow checking.
- `din`, in, WIDTH: value to push.
- `dout`, out, WIDTH: current top element (the top register).
- `count`, out, $clog2(DEPTH+1): number of elements currently stored.
- `empty`, out, 1: high when `count == 0`.
- `full`, out, 1: high when `count == DEPTH`.
- `overflow`, out, 1: sticky flag; present only with `STACK_ERR_EN`.
- `underflow`, out, 1: sticky flag; present only with `STACK_ERR_EN`.

## Operation
Storage:
- `top` register plus a `DEPTH-1` entry array `body[]`.
- Write pointer `sp` equals `count-1` when nonempty.
- `body[sp-1]` holds the element directly under the top.

Command decode, evaluated each cycle in this priority order:
- **push & pop, nonempty:** replace. `top <= din`; `count` unchanged; `body` untouched.
- **push & pop, empty:** behaves as a plain push.
- **push only, not full:**
  - If nonempty, `body[count-1] <= top`.
  - `top <= din`; `count <= count+1`.
- **push only, full:** ignored; state unchanged; sets `overflow`.
- **pop only, count > 1:** `top <= body[count-2]`; `count <= count-1`.
- **pop only, count == 1:** `top <= 0`; `count <= 0`.
- **pop only, empty:** ignored; sets `underflow`.
- **tos while empty:** sets `underflow`; no state change.
- **Idle:** hold all state.

Other rules:
- `count` never wraps. Saturation at 0 and at `DEPTH` comes from the reject rules above.
- `empty` and `full` are decoded combinationally from the `count` register.
- Reset values: `top = 0`, `count = 0` (so `dout = 0`, `empty = 1`, `full = 0`), `overflow = 0`, `underflow = 0`. `body[]` is not reset.
- Reset dominates any command in the same cycle. Reset mid-sequence discards all contents.

## Timing
- Commands are single-cycle and sampled on the rising `clk` edge. There is no handshake and no stall.
- `dout`, `count`, `empty` and `full` reflect a command on the cycle after the edge that samples it.
- Back-to-back commands are supported on every cycle.
- Between edges, `dout` is a direct register output, so the controller reads it combinationally with zero latency.
- With `STACK_ERR_EN`, error flags rise one cycle after the offending edge. They stay high until `rst`.

## Configuration
- `STACK_ERR_EN` defined:
  - `overflow` and `underflow` ports and their sticky registers exist.
  - Illegal commands are still ignored.
- `STACK_ERR_EN` undefined:
  - The ports are absent.
  - Illegal commands are silently ignored; all data-path behaviour is identical.

## Structure
- Shared package `stack_pkg` holds:
  - default `WIDTH` and `DEPTH` constants;
  - `localparam CNT_W = $clog2(DEPTH+1)`;
  - an enum `stack_cmd_e` {IDLE, PUSH, POP, REPL}, used for the decoded command and by the bench.
- One sub-module, `stack_ram`: the `DEPTH-1` × `WIDTH` array with one synchronous write port and an asynchronous read. The read address is `count-2` and the write address is `count-1`.
- The top register, counter, decode and flags stay in `stack_unit`.

## Test plan
1. Reset, then push 0x11, 0x22, 0x33 -> `dout` = 0x33, `count` = 3. Pop ×3 -> `dout` reads 0x22, then 0x11, then 0x00, with `empty` = 1.
2. Push `DEPTH` values 1..16 -> `full` = 1, `dout` = 16. Push 0xAA -> `dout` stays 16 and `count` stays 16; `overflow` = 1 with `STACK_ERR_EN`.
3. Pop on empty after reset -> `count` stays 0 and `dout` stays 0; `underflow` = 1. Repeat the test with `tos` alone -> same result.
4. Push 0x05, 0x07, then push & pop together with `din` = 0x09 -> `dout` = 0x09, `count` = 2. Pop -> `dout` = 0x05.
5. Assert push & pop together while empty with `din` = 0x3C -> `dout` = 0x3C, `count` = 1.
6. Push 5 values, assert `rst` in the same cycle as a push -> the next cycle shows `count` = 0, `dout` = 0, flags cleared. Then push 0x42 -> `dout` = 0x42, `count` = 1.
